// File: rtl/debug_uart_rx.sv
// 8N1 debug UART receiver feeding the debug receive stream with one-cycle error/overrun pulses.
// Define DEBUG_UART_RX_FIFO_EN for a 4-entry receive FIFO instead of a single holding register.
module debug_uart_rx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       uart_rx,
   input  logic       fifo_rx_rdy,
   output logic       fifo_rx_vld,
   output logic [7:0] fifo_rx_dat,
   output logic       rx_frame_err,
   output logic       rx_overrun,
   output logic       rx_busy
);
   // state   | meaning
   // IDLE    | line idle, waiting for a falling edge
   // START   | counting to mid start bit, rejecting glitches
   // DATA    | sampling 8 data bits LSB first at mid bit
   // STOP    | sampling the stop bit at mid bit
   // WAIT_HI | bad stop bit seen, waiting for the line to return high
   localparam int DIV  = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [1:0]      sync_q;
   logic            rx_s;
   logic            push;
   logic            frame_err_d;

   assign rx_s    = sync_q[1];
   assign rx_busy = (state_q != S_IDLE);

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         sync_q       <= 2'b11;
         rx_frame_err <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         sync_q       <= {sync_q[0], uart_rx};
         rx_frame_err <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      idx_d       = idx_q;
      shift_d     = shift_q;
      push        = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               if (rx_s) begin
                  push    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_WAIT_HI;
               end
            end
         end
         S_WAIT_HI: begin
            cnt_d = '0;
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef DEBUG_UART_RX_FIFO_EN
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [2:0] wr_ptr, rd_ptr;
   logic [7:0] mem [4];
   logic       empty, full, pop;

   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_ptr[2] != rd_ptr[2]) && (wr_ptr[1:0] == rd_ptr[1:0]);
   assign pop         = !empty && fifo_rx_rdy;
   assign fifo_rx_vld = !empty;
   assign fifo_rx_dat = mem[rd_ptr[1:0]];

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rx_overrun <= 1'b0;
         for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
      end else begin
         rx_overrun <= 1'b0;
         if (pop) rd_ptr <= rd_ptr + 3'd1;
         if (push) begin
            if (!full || pop) begin
               mem[wr_ptr[1:0]] <= shift_q;
               wr_ptr           <= wr_ptr + 3'd1;
            end else begin
               rx_overrun <= 1'b1;
            end
         end
      end
   end
`else
   logic       hold_vld;
   logic [7:0] hold_dat;

   assign fifo_rx_vld = hold_vld;
   assign fifo_rx_dat = hold_dat;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         hold_vld   <= 1'b0;
         hold_dat   <= 8'h00;
         rx_overrun <= 1'b0;
      end else begin
         rx_overrun <= 1'b0;
         if (push) begin
            if (!hold_vld || fifo_rx_rdy) begin
               hold_vld <= 1'b1;
               hold_dat <= shift_q;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (hold_vld && fifo_rx_rdy) begin
            hold_vld <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_debug_uart_rx.sv
// Directed bench for debug_uart_rx at DIV=10 / HALF=5; a frame starting in cycle t reports in cycle t+98.
module tb_debug_uart_rx;
   logic       sys_clk = 1'b0;
   logic       rst = 1'b1;
   logic       uart_rx = 1'b1;
   logic       fifo_rx_rdy = 1'b1;
   logic       fifo_rx_vld;
   logic [7:0] fifo_rx_dat;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   int         rx_cyc[$];
   logic [7:0] rx_dat[$];
   int         err_cyc[$];
   int         ovr_cyc[$];

   debug_uart_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
      .sys_clk      (sys_clk),
      .rst          (rst),
      .uart_rx      (uart_rx),
      .fifo_rx_rdy  (fifo_rx_rdy),
      .fifo_rx_vld  (fifo_rx_vld),
      .fifo_rx_dat  (fifo_rx_dat),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun),
      .rx_busy      (rx_busy)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(negedge sys_clk) begin
      if (fifo_rx_vld && fifo_rx_rdy) begin
         rx_cyc.push_back(cyc);
         rx_dat.push_back(fifo_rx_dat);
      end
      if (rx_frame_err) err_cyc.push_back(cyc);
      if (rx_overrun) ovr_cyc.push_back(cyc);
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      rx_cyc.delete();
      rx_dat.delete();
      err_cyc.delete();
      ovr_cyc.delete();
   endtask

   // Drives one frame; rst_at >= 0 asserts rst at that cycle offset until the frame ends.
   task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len,
                             input int rst_at, output int t_fall);
      t_fall = cyc;
      for (int i = 0; i < 90 + stop_len; i++) begin
         if (i < 10) uart_rx = 1'b0;
         else if (i < 90) uart_rx = d[(i - 10) / 10];
         else uart_rx = stop_v;
         if (i == rst_at) rst = 1'b1;
         if (rst_at >= 0 && i == rst_at + 1) begin
            chk("rst_vld", {31'd0, fifo_rx_vld}, 32'd0);
            chk("rst_dat", {24'd0, fifo_rx_dat}, 32'd0);
            chk("rst_err_ovr", {30'd0, rx_frame_err, rx_overrun}, 32'd0);
            chk("rst_busy", {31'd0, rx_busy}, 32'd0);
         end
         tick();
      end
      uart_rx = 1'b1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop_ok;
   } vec_t;

   vec_t vecs[5];
   int   t, t1, t2;

   initial begin
      vecs[0] = '{8'h55, 1'b1};
      vecs[1] = '{8'hA5, 1'b1};
      vecs[2] = '{8'h00, 1'b0};
      vecs[3] = '{8'hA5, 1'b1};
      vecs[4] = '{8'h3C, 1'b1};

      idle(3);
      chk("reset_vld", {31'd0, fifo_rx_vld}, 32'd0);
      chk("reset_dat", {24'd0, fifo_rx_dat}, 32'd0);
      chk("reset_busy", {31'd0, rx_busy}, 32'd0);
      chk("reset_pulses", {30'd0, rx_frame_err, rx_overrun}, 32'd0);
      rst = 1'b0;
      idle(5);

      // Good frames and a broken stop bit held low for 30 cycles.
      for (int v = 0; v < 5; v++) begin
         clear_logs();
         send_frame(vecs[v].data, vecs[v].stop_ok, vecs[v].stop_ok ? 10 : 30, -1, t);
         idle(20);
         chk("vec_ovr_none", ovr_cyc.size(), 0);
         if (vecs[v].stop_ok) begin
            chk("vec_rx_count", rx_cyc.size(), 1);
            chk("vec_err_none", err_cyc.size(), 0);
            if (rx_cyc.size() > 0) begin
               chk("vec_rx_time", rx_cyc[0] - t, 98);
               chk("vec_rx_data", {24'd0, rx_dat[0]}, {24'd0, vecs[v].data});
            end
         end else begin
            chk("vec_err_count", err_cyc.size(), 1);
            chk("vec_rx_none", rx_cyc.size(), 0);
            if (err_cyc.size() > 0) chk("vec_err_time", err_cyc[0] - t, 98);
         end
      end

      // Start-bit glitch: 3 low cycles only.
      clear_logs();
      t = cyc;
      uart_rx = 1'b0;
      idle(3);
      uart_rx = 1'b1;
      chk("glitch_busy_t1", {31'd0, rx_busy}, 32'd1);
      idle(4);
      chk("glitch_busy_t5", {31'd0, rx_busy}, 32'd1);
      tick();
      chk("glitch_idle_t6", {31'd0, rx_busy}, 32'd0);
      idle(20);
      chk("glitch_no_rx", rx_cyc.size(), 0);
      chk("glitch_no_err", err_cyc.size(), 0);

      // Overrun with the consumer stalled.
      clear_logs();
      fifo_rx_rdy = 1'b0;
`ifdef DEBUG_UART_RX_FIFO_EN
      send_frame(8'h11, 1'b1, 10, -1, t1);
      send_frame(8'h22, 1'b1, 10, -1, t);
      send_frame(8'h33, 1'b1, 10, -1, t);
      send_frame(8'h44, 1'b1, 10, -1, t);
      send_frame(8'h55, 1'b1, 10, -1, t2);
      idle(20);
      chk("ovr_count", ovr_cyc.size(), 1);
      if (ovr_cyc.size() > 0) chk("ovr_time", ovr_cyc[0] - t2, 98);
      chk("ovr_head", {24'd0, fifo_rx_dat}, 32'h11);
      fifo_rx_rdy = 1'b1;
      idle(8);
      chk("drain_count", rx_dat.size(), 4);
      for (int i = 0; i < 4 && i < rx_dat.size(); i++)
         chk("drain_data", {24'd0, rx_dat[i]}, 32'h11 * (i + 1));
      chk("drain_empty", {31'd0, fifo_rx_vld}, 32'd0);
`else
      send_frame(8'h11, 1'b1, 10, -1, t1);
      send_frame(8'h22, 1'b1, 10, -1, t2);
      idle(20);
      chk("ovr_count", ovr_cyc.size(), 1);
      if (ovr_cyc.size() > 0) chk("ovr_time", ovr_cyc[0] - t2, 98);
      chk("ovr_hold_vld", {31'd0, fifo_rx_vld}, 32'd1);
      chk("ovr_hold_dat", {24'd0, fifo_rx_dat}, 32'h11);
      fifo_rx_rdy = 1'b1;
      idle(3);
      chk("drain_count", rx_dat.size(), 1);
      if (rx_dat.size() > 0) chk("drain_data", {24'd0, rx_dat[0]}, 32'h11);
      chk("drain_empty", {31'd0, fifo_rx_vld}, 32'd0);
`endif

      // Reset in the middle of data bit 3, then a clean 0xC3.
      clear_logs();
      send_frame(8'h5A, 1'b1, 10, 45, t);
      idle(20);
      chk("rst_no_output", rx_cyc.size() + err_cyc.size() + ovr_cyc.size(), 0);
      send_frame(8'hC3, 1'b1, 10, -1, t);
      idle(20);
      chk("post_rst_count", rx_cyc.size(), 1);
      if (rx_cyc.size() > 0) begin
         chk("post_rst_time", rx_cyc[0] - t, 98);
         chk("post_rst_data", {24'd0, rx_dat[0]}, 32'hC3);
      end

      // Back-to-back frames with no idle gap.
      clear_logs();
      send_frame(8'h01, 1'b1, 10, -1, t1);
      send_frame(8'h80, 1'b1, 10, -1, t);
      send_frame(8'hFF, 1'b1, 10, -1, t);
      idle(20);
      chk("b2b_count", rx_cyc.size(), 3);
      if (rx_cyc.size() == 3) begin
         chk("b2b_t0", rx_cyc[0] - t1, 98);
         chk("b2b_t1", rx_cyc[1] - t1, 198);
         chk("b2b_t2", rx_cyc[2] - t1, 298);
         chk("b2b_d0", {24'd0, rx_dat[0]}, 32'h01);
         chk("b2b_d1", {24'd0, rx_dat[1]}, 32'h80);
         chk("b2b_d2", {24'd0, rx_dat[2]}, 32'hFF);
      end
      chk("b2b_no_err", err_cyc.size() + ovr_cyc.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
